// File: rtl/mul_seq_pkg.sv
// mul_seq_pkg: shared state encoding and algorithm-select constants for the
// sequential multiplier.
package mul_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic MODE_REPADD   = 1'b0;
   localparam logic MODE_SHIFTADD = 1'b1;

endpackage

// File: rtl/mul_seq_datapath.sv
// mul_seq_datapath: A/B/P registers with a shared PW-bit adder; one step is
// either a repeated-addition iteration or a shift-add iteration.
module mul_seq_datapath
   import mul_seq_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ld,
   input  logic                 clr_p,
   input  logic                 step,
   input  logic                 mode_r,
   input  logic [WIDTH-1:0]     a_in,
   input  logic [WIDTH-1:0]     b_in,
   output logic                 eqz,
   output logic [2*WIDTH-1:0]   product
);

   localparam int PW = 2 * WIDTH;

   logic [PW-1:0]    a_q, a_d, p_q, p_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             shift, add;

   always_comb begin
      shift = mode_r == MODE_SHIFTADD;
      // Shift-add only accumulates on a set multiplier LSB; repeated addition always does.
      add   = step && (!shift || b_q[0]);
      a_d   = ld ? {{WIDTH{1'b0}}, a_in} : (step && shift) ? a_q << 1 : a_q;
      b_d   = ld ? b_in : step ? (shift ? b_q >> 1 : b_q - WIDTH'(1)) : b_q;
      p_d   = clr_p ? '0 : add ? p_q + a_q : p_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q <= '0;
         b_q <= '0;
         p_q <= '0;
      end else begin
         a_q <= a_d;
         b_q <= b_d;
         p_q <= p_d;
      end
   end

   assign eqz     = b_q == '0;
   assign product = p_q;

endmodule

// File: rtl/mul_seq_unit.sv
// mul_seq_unit: start/busy/done sequential multiplier; the FSM steps the
// datapath until the multiplier register reaches zero.
module mul_seq_unit
   import mul_seq_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 mode,
   input  logic [WIDTH-1:0]     a_in,
   input  logic [WIDTH-1:0]     b_in,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   state_t state_q, state_d;
   logic   mode_q, mode_d;
   logic   ld, step, eqz;

   always_comb begin
      ld      = state_q == IDLE && start;
      step    = state_q == RUN && !eqz;
      mode_d  = ld ? mode : mode_q;
      state_d = (state_q == IDLE) ? (start ? RUN : IDLE) :
                (state_q == RUN)  ? (eqz ? DONE : RUN)   : IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         mode_q  <= MODE_REPADD;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
      end
   end

   assign busy = state_q != IDLE;
   assign done = state_q == DONE;

   mul_seq_datapath #(.WIDTH(WIDTH)) u_dp (
      .clk     (clk),
      .rst     (rst),
      .ld      (ld),
      .clr_p   (ld),
      .step    (step),
      .mode_r  (mode_q),
      .a_in    (a_in),
      .b_in    (b_in),
      .eqz     (eqz),
      .product (product)
   );

endmodule

// File: tb/tb_mul_seq_unit.sv
// tb_mul_seq_unit: directed and randomized jobs checked every cycle against a
// cycle-count/product model derived from the latency and arithmetic rules.
module tb_mul_seq_unit;

   localparam int W  = 16;
   localparam int PW = 2 * W;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          mode = 1'b0;
   logic [W-1:0]  a_in = '0;
   logic [W-1:0]  b_in = '0;
   logic          busy, done;
   logic [PW-1:0] product;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;

   mul_seq_unit #(.WIDTH(W)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .mode    (mode),
      .a_in    (a_in),
      .b_in    (b_in),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int lat_of(input logic md, input logic [W-1:0] b);
      int n = 0;
      if (md == 1'b0) n = int'(b);
      else for (int i = 0; i < W; i++) if (b[i]) n = i + 1;
      return n + 2;
   endfunction

   // Model: job accepted in IDLE, then a pure cycle count to the done cycle.
   logic          m_busy;
   int            m_t, m_end;
   logic [PW-1:0] m_res;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy <= 1'b0;
         m_t    <= 0;
         m_end  <= 0;
         m_res  <= '0;
      end else if (!m_busy) begin
         if (start) begin
            m_busy <= 1'b1;
            m_t    <= 1;
            m_end  <= lat_of(mode, b_in);
            m_res  <= PW'(a_in) * PW'(b_in);
         end
      end else begin
         m_t <= m_t + 1;
         if (m_t == m_end) m_busy <= 1'b0;
      end
   end

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, got, exp, cyc);
      end
   endtask

   task automatic run_job(input logic md, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int exp_lat, input logic [PW-1:0] exp_p, input string nm);
      int c0;
      bit got;
      @(negedge clk);
      start = 1'b1; mode = md; a_in = a; b_in = b; c0 = cyc;
      @(negedge clk);
      start = 1'b0; a_in = 16'h9999; b_in = 16'h9999;
      got = 0;
      for (int i = 0; i < 400; i++) begin
         if (done) begin got = 1; break; end
         @(negedge clk);
      end
      if (!got) chk({nm, " done timeout"}, 64'd0, 64'd1);
      else begin
         chk({nm, " latency"}, 64'(cyc - c0), 64'(exp_lat));
         chk({nm, " product"}, 64'(product), 64'(exp_p));
      end
   endtask

   initial begin
      int c1;
      logic          md;
      logic [W-1:0]  ra, rb;
      fork
         forever begin
            @(negedge clk);
            chk("busy", 64'(busy), 64'(m_busy));
            chk("done", 64'(done), 64'(m_busy && m_t == m_end));
            if (!m_busy || m_t == m_end) chk("product", 64'(product), 64'(m_res));
         end
      join_none

      #3;
      chk("reset busy", 64'(busy), 64'd0);
      chk("reset done", 64'(done), 64'd0);
      chk("reset product", 64'(product), 64'd0);
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;

      // Async reset in cycle 3 of a 7x5 job.
      @(negedge clk);
      start = 1'b1; mode = 1'b0; a_in = 16'd7; b_in = 16'd5;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async rst busy", 64'(busy), 64'd0);
      chk("async rst done", 64'(done), 64'd0);
      chk("async rst product", 64'(product), 64'd0);
      @(negedge clk);
      #2 rst = 1'b0;
      repeat (12) @(negedge clk);
      chk("post-rst done", 64'(done), 64'd0);

      run_job(1'b0, 16'd7, 16'd5, 7, 32'h0000_0023, "rep 7x5");
      run_job(1'b1, 16'hFFFF, 16'hFFFF, 18, 32'hFFFE_0001, "sa max");
      run_job(1'b1, 16'd3, 16'h0004, 5, 32'd12, "sa 3x4");
      run_job(1'b0, 16'd1234, 16'd0, 2, 32'd0, "rep b0");
      run_job(1'b1, 16'd1234, 16'd0, 2, 32'd0, "sa b0");
      run_job(1'b0, 16'd0, 16'd3, 5, 32'd0, "rep a0");

      // Start pulses while busy must be ignored.
      @(negedge clk);
      start = 1'b1; mode = 1'b0; a_in = 16'd6; b_in = 16'd4; c1 = cyc;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      start = 1'b1; a_in = 16'd9; b_in = 16'd9;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      start = 1'b1;
      chk("ign done cycle", 64'(cyc - c1), 64'd6);
      chk("ign done", 64'(done), 64'd1);
      chk("ign product", 64'(product), 64'd24);
      @(negedge clk);
      start = 1'b0;
      chk("ign idle busy", 64'(busy), 64'd0);
      repeat (8) @(negedge clk);
      chk("ign single done", 64'(busy), 64'd0);

      // Back-to-back: start held from the done cycle is taken in the next IDLE cycle.
      run_job(1'b1, 16'd2, 16'd3, 4, 32'd6, "b2b first");
      start = 1'b1; mode = 1'b1; a_in = 16'd5; b_in = 16'd5; c1 = cyc + 1;
      @(negedge clk);
      chk("b2b idle", 64'(busy), 64'd0);
      @(negedge clk);
      chk("b2b accepted", 64'(busy), 64'd1);
      for (int i = 0; i < 20 && !done; i++) @(negedge clk);
      start = 1'b0;
      chk("b2b latency", 64'(cyc - c1), 64'd5);
      chk("b2b product", 64'(product), 64'd25);

      for (int j = 0; j < 40; j++) begin
         md = 1'($urandom);
         ra = W'($urandom);
         rb = md ? W'($urandom) : W'($urandom_range(0, 40));
         if (j % 7 == 0) rb = '0;
         run_job(md, ra, rb, lat_of(md, rb), PW'(ra) * PW'(rb), "random");
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mul_seq_unit.md
Name: mul_seq_unit

Overview:
Parametrised sequential integer multiplier built from a datapath sub-module and an FSM controller. It supports two run-time selectable algorithms: repeated addition (B iterations) and shift-add (early-terminating at B's highest set bit). Operands are unsigned WIDTH bits; the product is a full 2*WIDTH bits. A start/busy/done handshake lets a host controller issue back-to-back jobs.

Parameters:
WIDTH, 16, operand width in bits (>=2); product width PW = 2*WIDTH is a derived localparam.

Ports:
clk  input  1  rising-edge clock, single clock domain
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
mode  input  1  0 = repeated addition, 1 = shift-add; captured with operands
a_in  input  WIDTH  multiplicand, captured on accepted start
b_in  input  WIDTH  multiplier, captured on accepted start
busy  output  1  high in LOAD-free RUN and DONE states (not IDLE)
done  output  1  one-cycle pulse: product valid
product  output  2*WIDTH  product register P; valid from done cycle until next accepted start

Behaviour:
- Reset (async, any state): state=IDLE, A=0, B=0, P=0, mode_r=0; busy=0, done=0, product=0. Reset mid-operation abandons the job; no done is issued.
- States: IDLE, RUN, DONE.
- IDLE: busy=0. If start=1 at the clock edge: A <= zero-extended a_in (PW bits), B <= b_in, P <= 0, mode_r <= mode; go to RUN. Otherwise hold; P is retained.
- RUN: busy=1.
  - If B==0 at the edge: go to DONE; P unchanged.
  - Else, mode_r=0: P <= P + A; B <= B - 1.
  - Else, mode_r=1: if B[0], P <= P + A; A <= A << 1; B <= B >> 1.
- DONE: busy=1, done=1 for exactly this cycle; go to IDLE unconditionally.
- start is ignored in RUN and DONE. Operand inputs are don't-care outside an accepted start.
- Latency, counting the start cycle as cycle 0:
  - done is high in cycle n+2.
  - mode 0: n = b.
  - mode 1: n = index of b's highest set bit + 1, at most WIDTH.
  - b=0: done in cycle 2 in both modes.
- Arithmetic: all additions are PW bits wide and cannot overflow (a*b < 2^PW). The mode-1 shift of A discards nothing within WIDTH iterations. The B decrement never wraps, because B==0 is checked first.
- a=0 is not short-circuited; the iteration count depends on b only.
- Earliest next accepted start is the IDLE cycle following DONE, i.e. cycle n+3.
- mode 0 worst case: 2^WIDTH - 1 iterations. This is documented, not guarded.

Decomposition:
- Package mul_seq_pkg:
  - state enum (IDLE, RUN, DONE) as 2-bit encoding.
  - mode constants MODE_REPADD=1'b0, MODE_SHIFTADD=1'b1.
- Sub-module mul_seq_datapath(WIDTH):
  - A, B, P registers, PW-bit adder, shifter/decrementer muxing, B==0 detect (eqz).
  - Controlled by ld, clr_p, step, and mode_r.
- The FSM lives in mul_seq_unit and drives those controls from eqz.

Test Plan:
1. Assert rst in cycle 3 of a mode-0 job (a=7, b=5) -> busy=0, done=0, product=0 immediately (async), state IDLE, no done pulse afterwards.
2. mode=0, a=7, b=5 -> product=35 (0x00000023), done high only in cycle 7, busy high in cycles 1-7.
3. mode=1, a=16'hFFFF, b=16'hFFFF -> product=32'hFFFE0001, done in cycle 18; mode=1, a=3, b=16'h0004 -> product=12, done in cycle 5.
4. b=0, a=1234, both modes -> product=0, done in cycle 2; a=0, b=3, mode 0 -> product=0, done in cycle 5.
5. Job a=6, b=4, mode 0; pulse start with a=9, b=9 in cycle 3 and again in the DONE cycle -> both ignored, product=24, a single done.
6. Back-to-back: after job 1 (a=2, b=3, mode 1 -> 6, done in cycle 4), hold start=1 with a=5, b=5 -> accepted in cycle 5 (IDLE), product=25 with done 5 cycles later.
